// File: rtl/clock_monitor_pkg.sv
// rtl/clock_monitor_pkg.sv - shared FSM encoding and defaults for the divided-clock monitor
package clock_monitor_pkg;

  localparam int DEFAULT_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

endpackage

// File: rtl/clock_monitor_sync.sv
// rtl/clock_monitor_sync.sv - synchronizer and rising-edge detector for the monitored clock
module clock_monitor_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mon_clk,
  input  logic enable,
  output logic tick
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  // Chain and history reset high so a clock already high (or rising with
  // reset) is never mistaken for a fresh edge once reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '1;
      prev   <= 1'b1;
      tick   <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], mon_clk};
      prev   <= stages[SYNC_STAGES-1];
      tick   <= stages[SYNC_STAGES-1] & ~prev & enable;
    end
  end

endmodule

// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - measures divided-clock period and reports lock, fault and timeout
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 2
) (
  input  logic             clock_monitor_clk,
  input  logic             clock_monitor_rst,
  input  logic             clock_monitor_mon_clk,
  input  logic             clock_monitor_enable,
  input  logic [CNT_W-1:0] clock_monitor_expected,
  output logic             clock_monitor_tick,
  output logic [CNT_W-1:0] clock_monitor_period,
  output logic             clock_monitor_valid,
  output logic             clock_monitor_locked,
  output logic             clock_monitor_fault,
  output logic             clock_monitor_timeout
);

  localparam int               MC_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W + 1)'(TOL);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] exp_q;
  logic [MC_W-1:0]  match_cnt;
  logic [CNT_W:0]   diff;
  logic             match;
  logic             saturated;
  logic             tick;

  clock_monitor_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clock_monitor_clk),
    .rst    (clock_monitor_rst),
    .mon_clk(clock_monitor_mon_clk),
    .enable (clock_monitor_enable),
    .tick   (tick)
  );

  assign clock_monitor_tick = tick;
  assign saturated          = (counter == CNT_MAX);

  // One extra bit keeps the absolute difference free of wrap-around.
  always_comb begin
    diff  = ({1'b0, counter} >= {1'b0, exp_q}) ? ({1'b0, counter} - {1'b0, exp_q})
                                               : ({1'b0, exp_q} - {1'b0, counter});
    match = (diff <= TOL_W);
  end

  always_ff @(posedge clock_monitor_clk) begin
    if (clock_monitor_rst || !clock_monitor_enable) begin
      state                 <= ST_IDLE;
      counter               <= '0;
      match_cnt             <= '0;
      clock_monitor_period  <= '0;
      clock_monitor_valid   <= 1'b0;
      clock_monitor_locked  <= 1'b0;
      clock_monitor_fault   <= 1'b0;
      clock_monitor_timeout <= 1'b0;
      if (clock_monitor_rst) exp_q <= '0;
    end else begin
      clock_monitor_valid <= 1'b0;
      if (state == ST_IDLE) begin
        state   <= ST_ARM;
        exp_q   <= clock_monitor_expected;
        counter <= '0;
      end else begin
        if (tick)            counter <= CNT_W'(1);
        else if (!saturated) counter <= counter + CNT_W'(1);

        // A tick always beats saturation: the edge did arrive.
        case (state)
          ST_ARM: begin
            if (tick) begin
              state <= ST_MEASURE;
            end else if (saturated) begin
              clock_monitor_timeout <= 1'b1;
              state                 <= ST_FAULT;
            end
          end
          ST_MEASURE: begin
            if (tick) begin
              clock_monitor_period <= counter;
              clock_monitor_valid  <= 1'b1;
              if (!match) begin
                match_cnt <= '0;
              end else if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                match_cnt            <= '0;
                state                <= ST_LOCKED;
                clock_monitor_locked <= 1'b1;
              end else begin
                match_cnt <= match_cnt + MC_W'(1);
              end
            end else if (saturated) begin
              clock_monitor_timeout <= 1'b1;
              state                 <= ST_FAULT;
            end
          end
          ST_LOCKED: begin
            if (tick) begin
              clock_monitor_period <= counter;
              clock_monitor_valid  <= 1'b1;
              if (!match) begin
                state                <= ST_FAULT;
                clock_monitor_fault  <= 1'b1;
                clock_monitor_locked <= 1'b0;
              end
            end else if (saturated) begin
              clock_monitor_timeout <= 1'b1;
              clock_monitor_locked  <= 1'b0;
              state                 <= ST_FAULT;
            end
          end
          ST_FAULT: begin
            if (tick) begin
              clock_monitor_period <= counter;
              clock_monitor_valid  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// tb/tb_clock_monitor.sv - scoreboard bench for clock_monitor
module tb_clock_monitor;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             mon_clk;
  logic             enable;
  logic [CNT_W-1:0] expected;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             locked;
  logic             fault;
  logic             timeout;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic             locked;
    logic             fault;
  } exp_t;

  exp_t sb[$];
  int   sp[$];
  bit   slk[$];
  bit   sft[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  clock_monitor #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .LOCK_COUNT (4),
    .TOL        (2)
  ) dut (
    .clock_monitor_clk     (clk),
    .clock_monitor_rst     (rst),
    .clock_monitor_mon_clk (mon_clk),
    .clock_monitor_enable  (enable),
    .clock_monitor_expected(expected),
    .clock_monitor_tick    (tick),
    .clock_monitor_period  (period),
    .clock_monitor_valid   (valid),
    .clock_monitor_locked  (locked),
    .clock_monitor_fault   (fault),
    .clock_monitor_timeout (timeout)
  );

  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got period=%0d with no expectation queued", period);
      end else begin
        e = sb.pop_front();
        if ({period, locked, fault} !== e) begin
          miscompares++;
          $display("FAIL period_report: got period=%0d locked=%b fault=%b want period=%0d locked=%b fault=%b",
                   period, locked, fault, e.period, e.locked, e.fault);
        end
      end
    end
  end

  task automatic pulse(input int p);
    @(negedge clk) mon_clk = 1'b1;
    @(negedge clk) mon_clk = 1'b0;
    repeat (p - 2) @(negedge clk);
  endtask

  task automatic drive_seq(input bit close);
    exp_t e;
    pulse(sp[0]);
    for (int i = 0; i < sp.size(); i++) begin
      e.period = CNT_W'(sp[i]);
      e.locked = slk[i];
      e.fault  = sft[i];
      sb.push_back(e);
      if (i + 1 < sp.size()) pulse(sp[i + 1]);
      else if (close)        pulse(4);
    end
    if (close) begin
      repeat (4) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
        miscompares++;
        $display("FAIL missing_valid: got %0d pending want 0", sb.size());
      end
    end
  endtask

  task automatic restart(input logic [CNT_W-1:0] e);
    @(negedge clk);
    enable  = 1'b0;
    mon_clk = 1'b0;
    @(negedge clk);
    vectors++;
    if ({locked, fault, timeout, valid, period} !== '0) begin
      miscompares++;
      $display("FAIL disable_clear: got l=%b f=%b t=%b v=%b p=%0d want all 0",
               locked, fault, timeout, valid, period);
    end
    sb.delete();
    expected = e;
    enable   = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; mon_clk = 1'b0; expected = 8'd10;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tick, valid, locked, fault, timeout} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00000", {tick, valid, locked, fault, timeout});
    end
    vectors++;
    if (period !== '0) begin
      miscompares++;
      $display("FAIL reset_period: got %0d want 0", period);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lock;
    restart(8'd10);
    sp = '{10, 10, 10, 10}; slk = '{0, 0, 0, 1}; sft = '{0, 0, 0, 0};
    drive_seq(1'b1);
    vectors++;
    if ({locked, fault} !== 2'b10) begin
      miscompares++;
      $display("FAIL lock_state: got l=%b f=%b want l=1 f=0", locked, fault);
    end
  endtask

  task automatic test_tolerance;
    restart(8'd10);
    sp  = '{13, 12, 11, 9, 13, 11, 9, 11, 9};
    slk = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    sft = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive_seq(1'b1);
  endtask

  task automatic test_fault;
    restart(8'd10);
    sp  = '{10, 10, 10, 10, 20, 10, 10};
    slk = '{0, 0, 0, 1, 0, 0, 0};
    sft = '{0, 0, 0, 0, 1, 1, 1};
    drive_seq(1'b1);
    vectors++;
    if ({locked, fault, timeout} !== 3'b010) begin
      miscompares++;
      $display("FAIL fault_sticky: got l=%b f=%b t=%b want 0 1 0", locked, fault, timeout);
    end
  endtask

  task automatic test_timeout;
    int cnt;
    restart(8'd10);
    sp = '{10, 10, 10, 10}; slk = '{0, 0, 0, 1}; sft = '{0, 0, 0, 0};
    drive_seq(1'b0);
    @(negedge clk) mon_clk = 1'b1;
    cnt = 0;
    while (timeout !== 1'b1 && cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) mon_clk = 1'b0;
    end
    // tick 3 cycles after the edge, counter loads 1 next, saturates 254 later
    vectors++;
    if (cnt != 259) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d cycles want 259", cnt);
    end
    vectors++;
    if ({locked, fault} !== 2'b00 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_state: got l=%b f=%b pending=%0d want 0 0 0", locked, fault, sb.size());
    end
    repeat (20) @(negedge clk);
    vectors++;
    if ({timeout, locked} !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout_sticky: got t=%b l=%b want 1 0", timeout, locked);
    end
  endtask

  task automatic test_reenable;
    restart(8'd10);
    sp = '{10, 10, 10, 10}; slk = '{0, 0, 0, 1}; sft = '{0, 0, 0, 0};
    drive_seq(1'b1);
    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    vectors++;
    if ({locked, fault, timeout, valid, period} !== '0) begin
      miscompares++;
      $display("FAIL reenable_clear: got l=%b f=%b t=%b p=%0d want all 0", locked, fault, timeout, period);
    end
    expected = 8'd20;
    enable   = 1'b1;
    @(negedge clk) expected = 8'd5;
    sp = '{20, 20, 20, 20}; slk = '{0, 0, 0, 1}; sft = '{0, 0, 0, 0};
    drive_seq(1'b1);
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL relock_20: got locked=%b want 1", locked);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   ticks;
    restart(8'd10);
    pulse(10);
    e.period = 8'd10; e.locked = 1'b0; e.fault = 1'b0;
    sb.push_back(e);
    pulse(10);
    @(negedge clk);
    rst     = 1'b1;
    mon_clk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({tick, valid, locked, fault, timeout, period} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got t=%b v=%b l=%b f=%b to=%b p=%0d want all 0",
               tick, valid, locked, fault, timeout, period);
    end
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tick === 1'b1) ticks++;
    end
    vectors++;
    if (ticks != 0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL reset_edge_tick: got ticks=%0d pending=%0d want 0 0", ticks, sb.size());
    end
    mon_clk = 1'b0;
  endtask

  initial begin
    test_reset;
    test_lock;
    test_tolerance;
    test_fault;
    test_timeout;
    test_reenable;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
